// File: rtl/dip_switch_conditioner.sv
// dip_switch_conditioner
// Front end for the raw DIP-switch word: synchronises it into clk, debounces
// the whole word at once, and publishes a committed value together with
// one-cycle change/match pulses and a registered equality level against the
// current target number.

module dip_switch_conditioner #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,   // must be >= 2
    parameter int STABLE_CYCLES = 16   // must be >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] target,
    input  logic             match_en,
    output logic [WIDTH-1:0] stable_value,
    output logic             stable,
    output logic             changed_pulse,
    output logic             match_pulse,
    output logic             equal
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    // Synchroniser chain; index 0 sees the raw pins
    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sampled;

    state_t           state_reg,         state_next;
    logic [WIDTH-1:0] cand_reg,          cand_next;
    logic [CNT_W-1:0] cnt_reg,           cnt_next;
    logic [WIDTH-1:0] stable_value_reg,  stable_value_next;
    logic             stable_reg,        stable_next;
    logic             changed_pulse_reg, changed_pulse_next;
    logic             match_pulse_reg,   match_pulse_next;
    logic             equal_reg,         equal_next;
    logic             commit;

    // Shift the switch word through the synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= sw_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // The last synchroniser stage is the only internal view of the pins
    assign sampled = sync_reg[SYNC_STAGES-1];

    // State and output registers of the debounce FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= ST_STABLE;
            cand_reg          <= '0;
            cnt_reg           <= '0;
            stable_value_reg  <= '0;
            stable_reg        <= 1'b1;
            changed_pulse_reg <= 1'b0;
            match_pulse_reg   <= 1'b0;
            equal_reg         <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cand_reg          <= cand_next;
            cnt_reg           <= cnt_next;
            stable_value_reg  <= stable_value_next;
            stable_reg        <= stable_next;
            changed_pulse_reg <= changed_pulse_next;
            match_pulse_reg   <= match_pulse_next;
            equal_reg         <= equal_next;
        end
    end

    // Next-state logic: track a candidate word until it has held long enough
    always_comb begin
        state_next        = state_reg;
        cand_next         = cand_reg;
        cnt_next          = cnt_reg;
        stable_value_next = stable_value_reg;
        stable_next       = stable_reg;
        commit            = 1'b0;

        case (state_reg)
            ST_STABLE: begin
                if (sampled != stable_value_reg) begin
                    cand_next   = sampled;
                    cnt_next    = '0;
                    state_next  = ST_SETTLING;
                    stable_next = 1'b0;
                end
            end
            ST_SETTLING: begin
                if (sampled == stable_value_reg) begin
                    // Glitch went away before committing: drop it silently
                    state_next  = ST_STABLE;
                    stable_next = 1'b1;
                end else if (sampled != cand_reg) begin
                    // Word still moving: restart the hold count on the new word
                    cand_next = sampled;
                    cnt_next  = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    commit            = 1'b1;
                    stable_value_next = cand_reg;
                    state_next        = ST_STABLE;
                    stable_next       = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next  = ST_STABLE;
                stable_next = 1'b1;
            end
        endcase

        // Pulses only ever accompany a commit, so a target move alone is silent
        changed_pulse_next = commit;
        match_pulse_next   = commit && (cand_reg == target) && match_en;
        // Compare the value that will be held after this edge so equal moves
        // together with a commit
        equal_next         = (stable_value_next == target);
    end

    assign stable_value  = stable_value_reg;
    assign stable        = stable_reg;
    assign changed_pulse = changed_pulse_reg;
    assign match_pulse   = match_pulse_reg;
    assign equal         = equal_reg;

endmodule

// File: tb/tb_dip_switch_conditioner.sv
// Testbench for dip_switch_conditioner: directed switch sequences; each
// expected commit is queued with its edge number and checked by a monitor
// that fires whenever the DUT emits a pulse.

module tb_dip_switch_conditioner;

    logic       clk;
    logic       rst_n;
    logic [7:0] sw_in;
    logic [7:0] target;
    logic       match_en;
    logic [7:0] stable_value;
    logic       stable;
    logic       changed_pulse;
    logic       match_pulse;
    logic       equal;

    dip_switch_conditioner #(
        .WIDTH         (8),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_in         (sw_in),
        .target        (target),
        .match_en      (match_en),
        .stable_value  (stable_value),
        .stable        (stable),
        .changed_pulse (changed_pulse),
        .match_pulse   (match_pulse),
        .equal         (equal)
    );

    typedef struct {
        int         cyc;
        logic [7:0] val;
        logic       mp;
        logic       eq;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_commit(input int c, input logic [7:0] v, input logic mp, input logic eq);
        exp_t e;
        e.cyc = c; e.val = v; e.mp = mp; e.eq = eq;
        sb_q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest queued commit
    always @(negedge clk) begin
        if (rst_n && (changed_pulse || match_pulse)) begin
            if (sb_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_pulse: changed=%0b match=%0b value=%0h at cyc %0d, required no pulse",
                         changed_pulse, match_pulse, stable_value, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("commit seen cyc %0d value %0h match %0b equal %0b (expected cyc %0d value %0h)",
                         cyc, stable_value, match_pulse, equal, e.cyc, e.val);
                chk("commit_cycle",  cyc,           e.cyc);
                chk("commit_value",  stable_value,  {24'h0, e.val});
                chk("changed_pulse", changed_pulse, 1);
                chk("match_pulse",   match_pulse,   e.mp);
                chk("commit_equal",  equal,         e.eq);
            end
        end
    end

    initial begin
        int n;
        int r;
        int m;
        int last;

        rst_n    = 1'b0;
        sw_in    = 8'h00;
        target   = 8'h00;
        match_en = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_stable_value", stable_value, 0);
        chk("rst_stable",       stable,       1);
        chk("rst_changed",      changed_pulse, 0);
        chk("rst_match",        match_pulse,  0);
        chk("rst_equal",        equal,        0);

        // Nonzero word at reset release commits at edge 19
        sw_in = 8'h01;
        @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        expect_commit(r + 19, 8'h01, 1'b0, 1'b0);
        wait_until(r + 25);
        chk("t1_value", stable_value, 8'h01);
        chk("t1_equal", equal, 0);

        // Matching commit
        n = cyc;
        sw_in = 8'hA5; target = 8'hA5; match_en = 1'b1;
        expect_commit(n + 19, 8'hA5, 1'b1, 1'b1);
        wait_until(n + 2);
        chk("t2_stable_before_capture", stable, 1);
        wait_until(n + 3);
        chk("t2_stable_after_capture", stable, 0);
        wait_until(n + 18);
        chk("t2_stable_last_settle", stable, 0);
        wait_until(n + 20);
        chk("t2_stable_after_commit", stable, 1);
        chk("t2_equal", equal, 1);
        wait_until(n + 24);
        chk("t2_equal_held", equal, 1);

        // Bouncing word, then holds 0x11
        n = cyc;
        last = 0;
        for (int k = 0; k < 12; k++) begin
            wait_until(n + 5 * k);
            sw_in = (k % 2 == 1) ? 8'h11 : 8'h10;
            if (k == 11) begin
                last = cyc;
                expect_commit(last + 19, 8'h11, 1'b0, 1'b0);
            end
        end
        wait_until(last + 25);
        chk("t3_value", stable_value, 8'h11);

        // Short glitch to 0x13 reverts without commit
        n = cyc;
        sw_in = 8'h13;
        wait_until(n + 4);
        sw_in = 8'h11;
        wait_until(n + 5);
        chk("t4_stable_low", stable, 0);
        wait_until(n + 8);
        chk("t4_stable_high", stable, 1);
        chk("t4_value", stable_value, 8'h11);

        // Target moves onto an unchanged stable value
        n = cyc;
        sw_in = 8'h22; target = 8'h05; match_en = 1'b1;
        expect_commit(n + 19, 8'h22, 1'b0, 1'b0);
        wait_until(n + 25);
        m = cyc;
        chk("t5_equal_before", equal, 0);
        target = 8'h22;
        wait_until(m + 1);
        chk("t5_equal_after", equal, 1);
        chk("t5_no_match", match_pulse, 0);
        wait_until(m + 4);
        chk("t5_no_match_later", match_pulse, 0);

        // Asynchronous reset mid-settle (cnt = 7)
        n = cyc;
        sw_in = 8'h33;
        wait_until(n + 10);
        chk("t6_settling", stable, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_value",   stable_value, 0);
        chk("t6_rst_stable",  stable,       1);
        chk("t6_rst_changed", changed_pulse, 0);
        chk("t6_rst_match",   match_pulse,  0);
        chk("t6_rst_equal",   equal,        0);
        @(negedge clk);
        @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        expect_commit(r + 19, 8'h33, 1'b0, 1'b0);
        wait_until(r + 18);
        chk("t6_value_before_commit", stable_value, 0);
        wait_until(r + 25);
        chk("t6_value", stable_value, 8'h33);
        chk("t6_stable", stable, 1);

        chk("pending_commits", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dip_switch_conditioner.md
Name: dip_switch_conditioner

Overview:
- Front-end stage between the raw DIP-switch pins (ui_in) and the game control logic.
- Synchronises the asynchronous switch word, debounces it as a whole word, and publishes a committed stable value.
- Produces a one-cycle change pulse and a one-cycle match pulse against the current target number.
- Game logic consumes these outputs instead of comparing raw switches, so bouncing switches cannot trigger false hits.

Parameters:
- WIDTH, 8, switch word width.
- SYNC_STAGES, 2, synchroniser flop depth; must be ≥2.
- STABLE_CYCLES, 16, consecutive identical samples required to commit; must be ≥2. Counter width is clog2(STABLE_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- sw_in  input  WIDTH  raw switch pins, asynchronous to clk.
- target  input  WIDTH  number the player must enter; synchronous to clk.
- match_en  input  1  enables match_pulse generation (game active).
- stable_value  output  WIDTH  last committed debounced switch word.
- stable  output  1  high when no change is settling.
- changed_pulse  output  1  one-cycle pulse on each commit of a new value.
- match_pulse  output  1  one-cycle pulse when the committed value equals target and match_en=1.
- equal  output  1  registered level: stable_value == target.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. Every register clears immediately on rst_n low, independent of clk.
- Reset values:
  - Synchroniser flops = 0, cand = 0, cnt = 0, stable_value = 0.
  - stable = 1, changed_pulse = 0, match_pulse = 0, equal = 0.
  - FSM state = STABLE.
- Synchroniser: SYNC_STAGES flops in series. "sampled" is the last flop's output and is the only internal view of sw_in.
- FSM states: STABLE and SETTLING.
- STABLE:
  - If sampled != stable_value: cand <= sampled, cnt <= 0, go to SETTLING, stable <= 0.
  - Otherwise hold.
- SETTLING, priority order:
  1. If sampled == stable_value (glitch reverted): go to STABLE, stable <= 1, no pulse, stable_value unchanged.
  2. Else if sampled != cand: cand <= sampled, cnt <= 0 (restart), stay in SETTLING.
  3. Else if cnt == STABLE_CYCLES-1: commit. stable_value <= cand, changed_pulse <= 1, go to STABLE, stable <= 1.
  4. Else cnt <= cnt+1.
- Commit latency: the commit edge is STABLE_CYCLES edges after the capture edge.
  - From sw_in changing and holding before edge 1, stable_value updates after edge SYNC_STAGES+1+STABLE_CYCLES.
  - With defaults, that is edge 19.
- match_pulse:
  - Asserted in the same cycle as changed_pulse, when cand == target and match_en == 1 at the commit edge.
  - Never asserted without a commit. If target changes to equal an unchanged stable_value, there is no pulse.
- equal: registered every cycle from the next-state stable_value compared to the current target. It updates in the same cycle as a commit, or one cycle after a target change.
- Both pulses are exactly one cycle wide. Back-to-back commits are at least STABLE_CYCLES+1 cycles apart, so pulses never merge.
- No arithmetic wrap: cnt never exceeds STABLE_CYCLES-1.
- Reset mid-SETTLING discards the candidate; no pulse is emitted.
- If sw_in is nonzero at reset release, the word settles normally and commits with a changed_pulse. The game logic relies on this for the start condition (stable_value == 1).

Test Plan:
- Reset, sw_in=0x01 held, target=0x00, match_en=0 -> changed_pulse for one cycle at edge 19 after release; stable_value=0x01; match_pulse=0; equal=0.
- From stable 0x01, set sw_in=0xA5, target=0xA5, match_en=1, hold -> stable low for 16 cycles after capture; at commit stable_value=0xA5, changed_pulse=1 and match_pulse=1 in the same single cycle; equal=1 from then on.
- Bounce: sw_in toggles 0x10/0x11 every 5 cycles for 60 cycles, then holds 0x11 -> no commit during bouncing; single commit to 0x11 exactly 16 edges after the last capture.
- Glitch: stable 0x11, sw_in pulses 0x13 for 4 cycles then returns to 0x11 -> stable returns high, no changed_pulse, stable_value stays 0x11.
- Target change: stable 0x22, match_en=1, target moves 0x05 -> 0x22 -> equal rises one cycle later; match_pulse stays 0.
- Async reset asserted mid-SETTLING (cnt=7), with no clock edge -> all outputs at reset values immediately; no pulse after release until a fresh 16-cycle settle completes.
